stopwatch_lap_core: RTL and testbench

STOPWATCH_LAP_CORE -- requirements
Module: stopwatch_lap_core

---
 rtl/stopwatch_pkg.sv | 64 ++++++
 rtl/sw_btn_edge.sv | 35 +++
 rtl/stopwatch_lap_core.sv | 246 ++++++++++++++++++++++++
 tb/tb_stopwatch_lap_core.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch lap core.
//   - sw_state_e : architectural state encoding, also visible on the state output
//   - BCD digit width, digit limits and the 32-bit hh:mm:ss:cc field layout
//   - bcd_tick() : advances a packed BCD time by one centisecond, wrapping 99:59:59.99 to zero
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_SPLIT   = 2'b10,
        ST_STOPPED = 2'b11
    } sw_state_e;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 8;
    localparam int TIME_W     = BCD_W * NUM_DIGITS;

    localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;

    // Digit positions (counted from cent_0) that are tens-of-seconds / tens-of-minutes
    localparam int SEC_1_IDX = 3;
    localparam int MIN_1_IDX = 5;

    // Field layout: hr_1 in [31:28] down to cent_0 in [3:0]
    typedef struct packed {
        logic [BCD_W-1:0] hr_1;
        logic [BCD_W-1:0] hr_0;
        logic [BCD_W-1:0] min_1;
        logic [BCD_W-1:0] min_0;
        logic [BCD_W-1:0] sec_1;
        logic [BCD_W-1:0] sec_0;
        logic [BCD_W-1:0] cent_1;
        logic [BCD_W-1:0] cent_0;
    } sw_time_t;

    // Ripple a carry from cent_0 upwards; a digit at its limit wraps to 0 and passes the carry on.
    // hr_1 wrapping past 9 gives the silent 99:59:59.99 -> 00:00:00.00 rollover.
    function automatic logic [TIME_W-1:0] bcd_tick(input logic [TIME_W-1:0] t);
        logic [TIME_W-1:0] r;
        logic              carry;
        logic [BCD_W-1:0]  lim;
        logic [BCD_W-1:0]  dig;
        r     = t;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lim = ((i == SEC_1_IDX) || (i == MIN_1_IDX)) ? DIGIT_MAX_5 : DIGIT_MAX_9;
            dig = r[i*BCD_W +: BCD_W];
            if (carry) begin
                if (dig == lim) begin
                    r[i*BCD_W +: BCD_W] = 4'd0;
                    carry = 1'b1;
                end else begin
                    r[i*BCD_W +: BCD_W] = dig + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                r[i*BCD_W +: BCD_W] = dig;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_btn_edge.sv
// Rising-edge detector for one raw button level.
//   clk, rst : clock and async active-low reset
//   btn_i    : raw button level
//   evt_o    : one-cycle event, high in the cycle after the registered sample goes 0->1
// evt_o is decoded purely from flops, so the consumer never sees a path from btn_i.
module sw_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic evt_o
);

    logic sample_q, sample_d;
    logic prev_q,   prev_d;

    // Next-state for the two-stage sample history
    always_comb begin
        sample_d = btn_i;
        prev_d   = sample_q;
    end

    // Sample history registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            sample_q <= sample_d;
            prev_q   <= prev_d;
        end
    end

    assign evt_o = sample_q & ~prev_q;

endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch core with split display and lap FIFO.
//   clk, rst                : clock, async active-low reset
//   start, stop, split      : raw button levels (edge detected internally)
//   lap_rd                  : pop request for the lap FIFO
//   run_time / disp_time    : live BCD time / displayed BCD time (frozen while in SPLIT)
//   state                   : IDLE=00 RUNNING=01 SPLIT=10 STOPPED=11
//   lap_data, lap_valid     : show-ahead head of the lap FIFO (0 when empty), non-empty flag
//   lap_count, lap_full     : stored entries, full flag
//   lap_ovf                 : sticky, a capture was dropped because the FIFO was full
module stopwatch_lap_core
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV      = 500000,
    parameter int LAP_DEPTH     = 8,
    parameter int SPLIT_HOLD_CS = 300
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         split,
    input  logic                         lap_rd,
    output logic [31:0]                  run_time,
    output logic [31:0]                  disp_time,
    output logic [1:0]                   state,
    output logic [31:0]                  lap_data,
    output logic                         lap_valid,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_full,
    output logic                         lap_ovf
);

    localparam int DIV_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(SPLIT_HOLD_CS + 1);
    localparam int PTR_W  = $clog2(LAP_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic start_evt_s, stop_evt_s, split_evt_s;
    logic start_s, stop_s, split_s;
    logic counting_s, tick_s, push_s, clear_s;
    logic pop_s, full_s, wr_en_s;

    sw_state_e           state_q, state_d;
    logic [TIME_W-1:0]   time_q,  time_d;
    logic [TIME_W-1:0]   frz_q,   frz_d;
    logic [TIME_W-1:0]   disp_q,  disp_d;
    logic [DIV_W-1:0]    div_q,   div_d;
    logic [HOLD_W-1:0]   hold_q,  hold_d;

    logic [TIME_W-1:0]   mem_q [LAP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic [TIME_W-1:0]   lap_data_q, lap_data_d;
    logic                ovf_q,    ovf_d;

    sw_btn_edge u_start_edge (.clk(clk), .rst(rst), .btn_i(start), .evt_o(start_evt_s));
    sw_btn_edge u_stop_edge  (.clk(clk), .rst(rst), .btn_i(stop),  .evt_o(stop_evt_s));
    sw_btn_edge u_split_edge (.clk(clk), .rst(rst), .btn_i(split), .evt_o(split_evt_s));

    // Event priority: stop masks start and split, start masks split
    always_comb begin
        stop_s  = stop_evt_s;
        start_s = start_evt_s & ~stop_evt_s;
        split_s = split_evt_s & ~stop_evt_s & ~start_evt_s;
    end

    // Divider, BCD time, split/hold FSM next-state
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        frz_d      = frz_q;
        div_d      = div_q;
        hold_d     = hold_q;
        push_s     = 1'b0;
        clear_s    = 1'b0;
        counting_s = (state_q == ST_RUNNING) || (state_q == ST_SPLIT);
        tick_s     = counting_s && (div_q == DIV_W'(TICK_DIV - 1));

        if (counting_s) begin
            div_d = tick_s ? '0 : div_q + DIV_W'(1);
        end else begin
            div_d = div_q;
        end

        if (tick_s) begin
            time_d = bcd_tick(time_q);
        end else begin
            time_d = time_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_RUNNING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUNNING: begin
                if (stop_s) begin
                    state_d = ST_STOPPED;
                end else if (split_s) begin
                    // Capture the pre-increment value of this edge
                    state_d = ST_SPLIT;
                    frz_d   = time_q;
                    hold_d  = '0;
                    push_s  = 1'b1;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_SPLIT: begin
                if (stop_s) begin
                    state_d = ST_STOPPED;
                end else if (split_s) begin
                    frz_d   = time_q;
                    hold_d  = '0;
                    push_s  = 1'b1;
                end else if (tick_s) begin
                    if (hold_q == HOLD_W'(SPLIT_HOLD_CS - 1)) begin
                        state_d = ST_RUNNING;
                        hold_d  = '0;
                    end else begin
                        hold_d  = hold_q + HOLD_W'(1);
                    end
                end else begin
                    state_d = ST_SPLIT;
                end
            end
            ST_STOPPED: begin
                if (start_s) begin
                    state_d = ST_RUNNING;
                end else if (split_s) begin
                    state_d = ST_IDLE;
                    clear_s = 1'b1;
                    time_d  = '0;
                    frz_d   = '0;
                    div_d   = '0;
                    hold_d  = '0;
                end else begin
                    state_d = ST_STOPPED;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        disp_d = (state_d == ST_SPLIT) ? frz_d : time_d;
    end

    // Lap FIFO next-state; a full FIFO still accepts a push when a pop frees a slot in the same cycle
    always_comb begin
        pop_s    = lap_rd && (cnt_q != '0);
        full_s   = (cnt_q == CNT_W'(LAP_DEPTH));
        wr_en_s  = push_s && (!full_s || pop_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;

        if (clear_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_en_s, pop_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
            if (push_s && full_s && !pop_s) begin
                ovf_d = 1'b1;
            end else begin
                ovf_d = ovf_q;
            end
        end

        // Show-ahead head; forward the incoming capture when it lands in the new head slot
        if (cnt_d == '0) begin
            lap_data_d = '0;
        end else if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            lap_data_d = time_q;
        end else begin
            lap_data_d = mem_q[rd_ptr_d];
        end
    end

    // Lap storage array (contents only meaningful below cnt_q)
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= time_q;
        end
    end

    // Core state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            frz_q      <= '0;
            disp_q     <= '0;
            div_q      <= '0;
            hold_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            lap_data_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            frz_q      <= frz_d;
            disp_q     <= disp_d;
            div_q      <= div_d;
            hold_q     <= hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            lap_data_q <= lap_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign run_time  = time_q;
    assign disp_time = disp_q;
    assign state     = state_q;
    assign lap_data  = lap_data_q;
    assign lap_valid = (cnt_q != '0);
    assign lap_count = cnt_q;
    assign lap_full  = (cnt_q == CNT_W'(LAP_DEPTH));
    assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Self-checking bench for stopwatch_lap_core: directed scenarios plus randomized button/pop
// traffic, checked every cycle against a model that keeps time as an integer centisecond count.
module tb_stopwatch_lap_core;
    import stopwatch_pkg::*;

    localparam int TICK_DIV      = 2;
    localparam int LAP_DEPTH     = 4;
    localparam int SPLIT_HOLD_CS = 3;
    localparam int WRAP_CS       = 36000000;

    logic        clk;
    logic        rst;
    logic        start, stop, split, lap_rd;
    logic [31:0] run_time, disp_time, lap_data;
    logic [1:0]  state;
    logic        lap_valid, lap_full, lap_ovf;
    logic [2:0]  lap_count;

    int n_checks;
    int n_errors;

    // Reference model
    int      m_mode;   // 0 idle, 1 running, 2 split, 3 stopped
    int      m_cs, m_div, m_hold, m_frz;
    bit      m_ovf;
    int      m_laps[$];
    bit [2:0] h1, h2;  // button levels seen at the last two edges: {split,start,stop}

    stopwatch_lap_core #(
        .TICK_DIV(TICK_DIV), .LAP_DEPTH(LAP_DEPTH), .SPLIT_HOLD_CS(SPLIT_HOLD_CS)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .split(split), .lap_rd(lap_rd),
        .run_time(run_time), .disp_time(disp_time), .state(state), .lap_data(lap_data),
        .lap_valid(lap_valid), .lap_count(lap_count), .lap_full(lap_full), .lap_ovf(lap_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int cs);
        int hh, mm, ss, cc;
        hh = cs / 360000;
        mm = (cs / 6000) % 60;
        ss = (cs / 100) % 60;
        cc = cs % 100;
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
                4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_cs = 0; m_div = 0; m_hold = 0; m_frz = 0; m_ovf = 1'b0;
        m_laps.delete();
        h1 = 3'b000; h2 = 3'b000;
    endtask

    task automatic model_edge();
        bit e_stop, e_start, e_split, tick, pop, push, clr, active;
        int cap;
        e_stop  = h1[0] && !h2[0];
        e_start = h1[1] && !h2[1] && !e_stop;
        e_split = h1[2] && !h2[2] && !e_stop && !e_start;
        h2 = h1;
        h1 = {split, start, stop};
        active = (m_mode == 1) || (m_mode == 2);
        tick = active && (m_div == TICK_DIV - 1);
        cap  = m_cs;
        if (active) m_div = tick ? 0 : m_div + 1;
        if (tick) m_cs = (m_cs + 1) % WRAP_CS;
        pop  = lap_rd && (m_laps.size() > 0);
        push = 1'b0;
        clr  = 1'b0;
        case (m_mode)
            0: if (e_start) m_mode = 1;
            1: begin
                if (e_stop) m_mode = 3;
                else if (e_split) begin m_mode = 2; m_frz = cap; m_hold = 0; push = 1'b1; end
            end
            2: begin
                if (e_stop) m_mode = 3;
                else if (e_split) begin m_frz = cap; m_hold = 0; push = 1'b1; end
                else if (tick) begin
                    m_hold++;
                    if (m_hold == SPLIT_HOLD_CS) begin m_mode = 1; m_hold = 0; end
                end
            end
            default: begin
                if (e_start) m_mode = 1;
                else if (e_split) clr = 1'b1;
            end
        endcase
        if (clr) begin
            m_mode = 0; m_cs = 0; m_div = 0; m_hold = 0; m_ovf = 1'b0;
            m_laps.delete();
        end else begin
            if (pop) void'(m_laps.pop_front());
            if (push) begin
                if (m_laps.size() < LAP_DEPTH) m_laps.push_back(cap);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("run_time", run_time, to_bcd(m_cs));
        chk("disp_time", disp_time, (m_mode == 2) ? to_bcd(m_frz) : to_bcd(m_cs));
        chk("state", 32'(state), 32'(m_mode));
        chk("lap_data", lap_data, (m_laps.size() > 0) ? to_bcd(m_laps[0]) : 32'h0);
        chk("lap_valid", 32'(lap_valid), 32'(m_laps.size() > 0));
        chk("lap_count", 32'(lap_count), 32'(m_laps.size()));
        chk("lap_full", 32'(lap_full), 32'(m_laps.size() == LAP_DEPTH));
        chk("lap_ovf", 32'(lap_ovf), 32'(m_ovf));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_run"}, run_time, 32'h0);
        chk({tag, "_disp"}, disp_time, 32'h0);
        chk({tag, "_state"}, 32'(state), 32'h0);
        chk({tag, "_data"}, lap_data, 32'h0);
        chk({tag, "_valid"}, 32'(lap_valid), 32'h0);
        chk({tag, "_count"}, 32'(lap_count), 32'h0);
        chk({tag, "_full"}, 32'(lap_full), 32'h0);
        chk({tag, "_ovf"}, 32'(lap_ovf), 32'h0);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse(input int which);
        if (which == 0) stop = 1'b1;
        else if (which == 1) start = 1'b1;
        else split = 1'b1;
        step();
        stop = 1'b0; start = 1'b0; split = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        start = 1'b0; stop = 1'b0; split = 1'b0; lap_rd = 1'b0;
        rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
        #1 check_zero("por");
        @(negedge clk);
        rst = 1'b1;
        compare_all();

        // Start and run 200 cycles: 100 ticks
        pulse(1);
        for (int i = 0; i < 200; i++) step();
        chk("run_1s", run_time, 32'h0000_0100);
        chk("run_state", 32'(state), 32'h1);

        // Five splits without pops: four stored, one dropped
        for (int i = 0; i < 5; i++) pulse(2);
        chk("ovf_count", 32'(lap_count), 32'd4);
        chk("ovf_full", 32'(lap_full), 32'h1);
        chk("ovf_flag", 32'(lap_ovf), 32'h1);
        lap_rd = 1'b1;
        for (int i = 0; i < 4; i++) step();
        lap_rd = 1'b0;
        step();
        chk("drain_count", 32'(lap_count), 32'h0);
        chk("drain_valid", 32'(lap_valid), 32'h0);

        // Simultaneous start/stop/split while running: stop wins
        for (int i = 0; i < 100 && m_mode != 1; i++) step();
        chk("wait_run", 32'(state), 32'h1);
        start = 1'b1; stop = 1'b1; split = 1'b1;
        step();
        start = 1'b0; stop = 1'b0; split = 1'b0;
        step();
        chk("prio_state", 32'(state), 32'h3);
        chk("prio_nolap", 32'(lap_count), 32'h0);

        // Split while stopped clears everything, including the sticky overflow
        pulse(2);
        check_zero("clear");

        // Split captured at 00:00:00.10, display frozen for three ticks
        pulse(1);
        for (int i = 0; i < 100 && !(m_cs == 9 && m_div == 1); i++) step();
        split = 1'b1;
        step();
        split = 1'b0;
        step();
        chk("split_data", lap_data, 32'h0000_0010);
        chk("split_count", 32'(lap_count), 32'h1);
        chk("split_disp", disp_time, 32'h0000_0010);
        for (int i = 0; i < 4; i++) step();
        chk("split_hold", disp_time, 32'h0000_0010);
        step();
        step();
        chk("split_release", disp_time, to_bcd(m_cs));
        chk("split_state", 32'(state), 32'h1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(4) == 0) stop  = ~stop;
            if ($urandom_range(4) == 0) start = ~start;
            if ($urandom_range(3) == 0) split = ~split;
            lap_rd = ($urandom_range(3) == 0);
            step();
        end
        start = 1'b0; stop = 1'b0; split = 1'b0; lap_rd = 1'b0;
        step();

        // BCD carry boundaries, including the silent 99:59:59.99 rollover
        chk("bcd_wrap", bcd_tick(32'h9959_5999), 32'h0000_0000);
        chk("bcd_cc", bcd_tick(32'h0000_0099), 32'h0000_0100);
        chk("bcd_ss", bcd_tick(32'h0000_5999), 32'h0001_0000);
        chk("bcd_mm", bcd_tick(32'h0059_5999), 32'h0100_0000);
        chk("bcd_hh", bcd_tick(32'h0959_5999), 32'h1000_0000);
        for (int i = 0; i < 20; i++) begin
            int k;
            k = int'($urandom_range(WRAP_CS - 2));
            chk("bcd_rand", bcd_tick(to_bcd(k)), to_bcd(k + 1));
        end

        // Reset mid-run: outputs clear without a clock edge
        pulse(0);
        pulse(1);
        for (int i = 0; i < 20; i++) step();
        chk("pre_rst_state", 32'(state), 32'h1);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        compare_all();
        pulse(1);
        for (int i = 0; i < 10; i++) step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
